// File: rtl/surf_byte_capture_multi_if.sv
// Channel bus between the capture block and its driver: control, data words and error status.
interface surf_byte_capture_multi_if #(
  parameter int NCHAN        = 2,
  parameter int WIDTH        = 8,
  parameter int ERRCNT_WIDTH = 16
);
  logic                          sync_i;
  logic [NCHAN-1:0]              capture_i;
  logic [NCHAN-1:0]              enable_i;
  logic [NCHAN-1:0]              err_clr_i;
  logic [NCHAN*WIDTH-1:0]        data_i;
  logic [NCHAN*WIDTH-1:0]        data_o;
  logic [NCHAN-1:0]              valid_o;
  logic [NCHAN-1:0]              biterr_o;
  logic [NCHAN*ERRCNT_WIDTH-1:0] errcnt_o;

  modport master (
    output sync_i, capture_i, enable_i, err_clr_i, data_i,
    input  data_o, valid_o, biterr_o, errcnt_o
  );

  modport slave (
    input  sync_i, capture_i, enable_i, err_clr_i, data_i,
    output data_o, valid_o, biterr_o, errcnt_o
  );
endinterface

// File: rtl/surf_byte_capture_multi.sv
// Multi-channel byte capture on a 2-cycle frame phase plus idle-pattern stability checking.
// Latency 2-3 cycles request to valid_o; no backpressure, valid_o is a 1-cycle pulse.
module surf_byte_capture_multi #(
  parameter int NCHAN        = 2,
  parameter int WIDTH        = 8,
  parameter int PERIOD       = 2,
  parameter int SETTLE       = 16,
  parameter int ERRCNT_WIDTH = 16
) (
  input  logic                     sysclk_i,
  input  logic                     rst_n_i,
  surf_byte_capture_multi_if.slave bus
);
  localparam int                      SW         = $clog2(SETTLE + 1);
  localparam logic [SW-1:0]           SETTLE_MAX = SW'(SETTLE);
  localparam logic [ERRCNT_WIDTH-1:0] ERR_SAT    = '1;

  logic                                   phase;
  logic [NCHAN-1:0]                       pending;
  logic [NCHAN-1:0]                       ce;
  logic [NCHAN-1:0]                       req;
  logic [NCHAN-1:0]                       armed;
  logic [NCHAN-1:0]                       err;
  logic [NCHAN-1:0]                       valid_q;
  logic [NCHAN-1:0]                       biterr_q;
  logic [NCHAN-1:0][WIDTH-1:0]            din;
  logic [NCHAN-1:0][WIDTH-1:0]            data_q;
  logic [NCHAN-1:0][PERIOD-1:0][WIDTH-1:0] hist;
  logic [NCHAN-1:0][SW-1:0]               settle;
  logic [NCHAN-1:0][ERRCNT_WIDTH-1:0]     errcnt_q;

  assign din          = bus.data_i;
  assign bus.data_o   = data_q;
  assign bus.valid_o  = valid_q;
  assign bus.biterr_o = biterr_q;
  assign bus.errcnt_o = errcnt_q;

  always_comb begin
    req   = bus.capture_i | pending | bus.enable_i;
    armed = '0;
    err   = '0;
    for (int k = 0; k < NCHAN; k++) begin
      armed[k] = (settle[k] == SETTLE_MAX) & ~bus.enable_i[k];
      err[k]   = armed[k] & (din[k] != hist[k][PERIOD-1]);
    end
  end

  always_ff @(posedge sysclk_i) begin
    if (!rst_n_i) begin
      phase    <= 1'b0;
      pending  <= '0;
      ce       <= '0;
      valid_q  <= '0;
      data_q   <= '0;
      biterr_q <= '0;
      errcnt_q <= '0;
      settle   <= '0;
      hist     <= '0;
    end else begin
      phase   <= bus.sync_i ? 1'b0 : ~phase;
      // A request landing on phase 1 is parked one cycle so the sample still falls on phase 1.
      pending <= (pending | bus.capture_i) & {NCHAN{phase}};
      ce      <= req & {NCHAN{~phase}};
      valid_q <= ce;
      for (int k = 0; k < NCHAN; k++) begin
        if (ce[k]) data_q[k] <= din[k];

        if (bus.enable_i[k]) settle[k] <= '0;
        else if (settle[k] != SETTLE_MAX) settle[k] <= settle[k] + 1'b1;

        // History freezes while the channel is live so the check resumes on the old pattern.
        if (!bus.enable_i[k]) begin
          for (int i = PERIOD - 1; i > 0; i--) hist[k][i] <= hist[k][i-1];
          hist[k][0] <= din[k];
        end

        if (armed[k]) biterr_q[k] <= err[k];

        if (bus.err_clr_i[k]) errcnt_q[k] <= ERRCNT_WIDTH'(err[k]);
        else if (err[k] && (errcnt_q[k] != ERR_SAT)) errcnt_q[k] <= errcnt_q[k] + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_surf_byte_capture_multi.sv
// Directed bench: capture expectations go through per-channel queues checked by a monitor.
module tb_surf_byte_capture_multi;
  localparam int NCHAN  = 2;
  localparam int WIDTH  = 8;
  localparam int PERIOD = 2;
  localparam int SETTLE = 16;
  localparam int EW     = 4;

  typedef struct {
    logic [7:0] d;
    int         cyc;
  } exp_t;

  logic sysclk_i = 1'b0;
  logic rst_n_i;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q0[$];
  exp_t q1[$];

  surf_byte_capture_multi_if #(.NCHAN(NCHAN), .WIDTH(WIDTH), .ERRCNT_WIDTH(EW)) bus ();

  surf_byte_capture_multi #(
    .NCHAN(NCHAN), .WIDTH(WIDTH), .PERIOD(PERIOD), .SETTLE(SETTLE), .ERRCNT_WIDTH(EW)
  ) dut (
    .sysclk_i(sysclk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  always #5 sysclk_i = ~sysclk_i;
  always @(posedge sysclk_i) cyc <= cyc + 1;

  task automatic tick();
    @(posedge sysclk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input int ch, input logic [7:0] d, input int c);
    exp_t e;
    e.d   = d;
    e.cyc = c;
    if (ch == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic set_d(input int k, input logic [7:0] v);
    bus.data_i[k*WIDTH +: WIDTH] = v;
  endtask

  function automatic logic [7:0] dout(input int k);
    return bus.data_o[k*WIDTH +: WIDTH];
  endfunction

  function automatic logic [EW-1:0] ecnt(input int k);
    return bus.errcnt_o[k*EW +: EW];
  endfunction

  task automatic do_reset();
    rst_n_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.sync_i    = 1'($urandom);
      bus.capture_i = NCHAN'($urandom);
      bus.enable_i  = NCHAN'($urandom);
      bus.err_clr_i = NCHAN'($urandom);
      bus.data_i    = (NCHAN*WIDTH)'($urandom);
      tick();
    end
  endtask

  task automatic release_rst();
    bus.sync_i    = 1'b0;
    bus.capture_i = '0;
    bus.enable_i  = '0;
    bus.err_clr_i = '0;
    bus.data_i    = '0;
    rst_n_i       = 1'b1;
  endtask

  // Scoreboard monitor: every valid_o pulse must match the oldest expected capture.
  always @(negedge sysclk_i) begin
    for (int k = 0; k < NCHAN; k++) begin
      if (bus.valid_o[k] === 1'b1) begin
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid ch%0d @cyc %0d: pulse seen, none expected", k, cyc);
        end else begin
          exp_t e;
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("cap_data_ch%0d", k), 32'(dout(k)), 32'(e.d));
          chk($sformatf("cap_cycle_ch%0d", k), cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    int a;
    int e;
    rst_n_i       = 1'b0;
    bus.sync_i    = 1'b0;
    bus.capture_i = '0;
    bus.enable_i  = '0;
    bus.err_clr_i = '0;
    bus.data_i    = '0;

    // Reset with random inputs
    do_reset();
    @(negedge sysclk_i);
    chk("rst_data_o", 32'(bus.data_o), 0);
    chk("rst_valid_o", 32'(bus.valid_o), 0);
    chk("rst_biterr_o", 32'(bus.biterr_o), 0);
    chk("rst_errcnt_o", 32'(bus.errcnt_o), 0);
    release_rst();
    tick(); tick(); tick();
    @(negedge sysclk_i);
    chk("post_rst_errcnt", 32'(bus.errcnt_o), 0);
    chk("post_rst_valid", 32'(bus.valid_o), 0);

    // One-shot capture requested on phase 0: two cycles to valid
    bus.sync_i = 1'b1; tick();
    bus.sync_i = 1'b0;
    bus.capture_i[0] = 1'b1; push(0, 8'hA5, cyc + 2); tick();
    bus.capture_i[0] = 1'b0; set_d(0, 8'hA5); tick();
    set_d(0, 8'h00); tick(); tick();

    // Request on phase 1: waits one cycle, three cycles to valid
    bus.sync_i = 1'b1; tick();
    bus.sync_i = 1'b0; tick();
    bus.capture_i[0] = 1'b1; push(0, 8'h3C, cyc + 3); tick();
    bus.capture_i[0] = 1'b0; set_d(0, 8'h00); tick();
    set_d(0, 8'h3C); tick();
    set_d(0, 8'h00); tick(); tick(); tick();

    // Continuous capture on ch1 with a coincident one-shot: odd words only, never doubled
    bus.sync_i = 1'b1; tick();
    bus.sync_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.enable_i[1]  = 1'b1;
      bus.capture_i[1] = (i == 0);
      set_d(1, 8'(i));
      if (i % 2 == 1) push(1, 8'(i), cyc + 1);
      tick();
    end
    bus.enable_i[1] = 1'b0;
    set_d(1, 8'h00);
    tick(); tick(); tick();
    @(negedge sysclk_i);
    chk("ch0_held", 32'(dout(0)), 32'h3C);
    chk("ch1_last", 32'(dout(1)), 32'h09);

    // Reset while a phase-1 request is pending: no pulse may follow
    bus.sync_i = 1'b1; tick();
    bus.sync_i = 1'b0; tick();
    bus.capture_i[0] = 1'b1; tick();
    bus.capture_i[0] = 1'b0;
    do_reset();
    release_rst();

    // Stable 55/AA pattern, one injected 5A word
    for (int i = 0; i < 40; i++) begin
      set_d(0, (i == 30) ? 8'h5A : ((i % 2 == 1) ? 8'hAA : 8'h55));
      @(negedge sysclk_i);
      if (i == 24) begin
        chk("pat_biterr_clean", 32'(bus.biterr_o[0]), 0);
        chk("pat_errcnt_clean", 32'(ecnt(0)), 0);
      end
      if (i == 31) begin
        chk("inj_biterr", 32'(bus.biterr_o[0]), 1);
        chk("inj_errcnt", 32'(ecnt(0)), 1);
      end
      if (i == 32) begin
        chk("inj_biterr_back", 32'(bus.biterr_o[0]), 0);
        chk("inj_errcnt_hold", 32'(ecnt(0)), 1);
      end
      if (i == 33) begin
        chk("hist_biterr", 32'(bus.biterr_o[0]), 1);
        chk("hist_errcnt", 32'(ecnt(0)), 2);
      end
      if (i == 35) begin
        chk("hist_biterr_back", 32'(bus.biterr_o[0]), 0);
        chk("hist_errcnt_hold", 32'(ecnt(0)), 2);
      end
      tick();
    end

    // Mismatch every cycle: saturate, then clear with and without a coincident error
    for (int j = 0; j < 16; j++) begin
      set_d(0, 8'(8'h10 + j));
      tick();
    end
    a = cyc;
    bus.err_clr_i[0] = 1'b1; set_d(0, 8'h20);
    @(negedge sysclk_i);
    chk("errcnt_sat", 32'(ecnt(0)), 15);
    chk("biterr_sat", 32'(bus.biterr_o[0]), 1);
    tick();
    bus.err_clr_i[0] = 1'b0; set_d(0, 8'h1F);
    @(negedge sysclk_i);
    chk("clr_with_err", 32'(ecnt(0)), 1);
    tick();
    bus.err_clr_i[0] = 1'b1; set_d(0, 8'h20);
    @(negedge sysclk_i);
    chk("clr_err_hold", 32'(ecnt(0)), 1);
    chk("clr_biterr_clean", 32'(bus.biterr_o[0]), 0);
    tick();
    bus.err_clr_i[0] = 1'b0; set_d(0, 8'h1F); bus.sync_i = 1'b1;
    @(negedge sysclk_i);
    chk("clr_alone", 32'(ecnt(0)), 0);
    chk("clr_cycle_span", cyc - a, 3);
    tick();

    // One-cycle enable (on phase 1) with bad data re-arms the settle window
    bus.sync_i = 1'b0; set_d(0, 8'h20); tick();
    e = cyc;
    bus.enable_i[0] = 1'b1; set_d(0, 8'hFF); tick();
    bus.enable_i[0] = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      set_d(0, 8'(8'h40 + k));
      @(negedge sysclk_i);
      if (k == 17) begin
        chk("settle_errcnt", 32'(ecnt(0)), 0);
        chk("settle_biterr", 32'(bus.biterr_o[0]), 0);
        chk("settle_cycle", cyc - e, 17);
      end
      tick();
    end
    @(negedge sysclk_i);
    chk("rearm_errcnt", 32'(ecnt(0)), 1);
    chk("rearm_biterr", 32'(bus.biterr_o[0]), 1);
    tick();

    tick(); tick(); tick(); tick();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
